// File: rtl/mem_responder_if.sv
// Bus between the pipeline's memory stage and mem_responder.
// The pipeline is the master: it drives the request and reads back the
// load data and the handshake flags.
interface mem_responder_if;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] Addr;
    logic [31:0] WData;
    logic [31:0] RData;
    logic        Done;
    logic        Err;
    logic        Stall;

    modport master (
        output MemRead, MemWrite, Addr, WData,
        input  RData, Done, Err, Stall
    );

    modport slave (
        input  MemRead, MemWrite, Addr, WData,
        output RData, Done, Err, Stall
    );
endinterface

// File: rtl/mem_responder.sv
// mem_responder: fixed-latency word memory behind a pipeline memory stage.
// A request taken in IDLE completes WAIT cycles later with a one-cycle Done
// pulse; Stall holds the pipeline until then. Out-of-range addresses and
// simultaneous read+write complete with Err and load RData with zero.
// Optional build macro: MEM_ALIGN_CHECK_EN turns a misaligned address
// (Addr[1:0] != 0) into an error; without it the low address bits are ignored.
module mem_responder #(
    parameter int DEPTH = 64,  // 32-bit words, power of two, 4..1024
    parameter int WAIT  = 2    // accept-to-completion latency, 1..15
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_responder_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state;
    logic [3:0]    cnt;
    logic [AW-1:0] idx_q;
    logic [31:0]   wdata_q;
    logic          rd_q;
    logic          wr_q;
    logic          bad_q;
    logic [31:0]   rdata_q;
    logic          done_q;
    logic          err_q;

    logic [31:0]   mem [DEPTH];

    logic          req;
    logic          in_bad;
    logic [AW-1:0] in_idx;
    logic [AW-1:0] cur_idx;
    logic          cur_rd;
    logic          cur_bad;
    logic          fin_next;
    logic          mem_we;

    assign req    = bus.MemRead | bus.MemWrite;
    assign in_idx = bus.Addr[AW+1:2];

`ifdef MEM_ALIGN_CHECK_EN
    assign in_bad = (|bus.Addr[31:AW+2]) | (bus.MemRead & bus.MemWrite) | (|bus.Addr[1:0]);
`else
    // Byte-offset bits are deliberately dropped in this build.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^bus.Addr[1:0];
    assign in_bad = (|bus.Addr[31:AW+2]) | (bus.MemRead & bus.MemWrite);
`endif

    // Select the operation that is about to complete: the incoming request when
    // WAIT=1 accepts and finishes on consecutive edges, otherwise the latched one.
    always_comb begin
        // NOTE: every output gets a default first so no latch is inferred.
        cur_idx  = idx_q;
        cur_rd   = rd_q;
        cur_bad  = bad_q;
        fin_next = 1'b0;
        if (state == IDLE) begin
            cur_idx  = in_idx;
            cur_rd   = bus.MemRead;
            cur_bad  = in_bad;
            fin_next = req && (WAIT == 1);
        end else begin
            fin_next = (cnt == 4'd1);
        end
    end

    // The write lands on the edge that ends the completion cycle.
    assign mem_we = (state == BUSY) && (cnt == 4'd0) && wr_q && !bad_q;

    // Stall is forced low during reset even if the pipeline still holds a request.
    assign bus.Stall = rst_n && (((state == IDLE) && req) || ((state == BUSY) && (cnt != 4'd0)));
    assign bus.RData = rdata_q;
    assign bus.Done  = done_q;
    assign bus.Err   = err_q;

    // Control FSM: accept, count down the latency, register RData/Done/Err.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            idx_q   <= '0;
            wdata_q <= 32'd0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            bad_q   <= 1'b0;
            rdata_q <= 32'd0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            done_q <= fin_next;
            err_q  <= fin_next && cur_bad;
            if (fin_next) begin
                if (cur_bad)     rdata_q <= 32'd0;
                else if (cur_rd) rdata_q <= mem[cur_idx];
            end
            case (state)
                IDLE: begin
                    if (req) begin
                        state   <= BUSY;
                        cnt     <= 4'(WAIT - 1);
                        idx_q   <= in_idx;
                        wdata_q <= bus.WData;
                        rd_q    <= bus.MemRead;
                        wr_q    <= bus.MemWrite;
                        bad_q   <= in_bad;
                    end
                end
                BUSY: begin
                    if (cnt == 4'd0) state <= IDLE;
                    else             cnt   <= cnt - 4'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Word array write port.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset; its contents must survive rst_n, and a
        // write abandoned by reset is blocked because the FSM leaves BUSY.
        if (mem_we) mem[idx_q] <= wdata_q;
    end
endmodule
